// File: rtl/cpu_mem_responder_pkg.sv
// Shared definitions for the CPU memory responder: loader state encoding,
// bus widths and the tohost mailbox address.
package cpu_mem_responder_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;

    // Mailbox address used when MEM_RESP_TOHOST_EN is defined
    localparam logic [WORD_W-1:0] TOHOST_ADDR = 32'hFFFF_FFF0;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/cpu_mem_responder_boot_loader.sv
// Byte-stream boot loader: assembles big-endian bytes into words, drives the
// instruction-memory write port, and holds the CPU in reset until the image ends.
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   load_valid/load_byte/load_last    byte stream in (last qualified by valid)
//   load_ready                        byte accepted when valid && ready
//   cpu_reset                         high while loading
//   load_overflow                     sticky: image longer than IMEM
//   imem_we_c/imem_waddr_c/imem_wdata_c  IMEM write port, written at this posedge
module cpu_mem_responder_boot_loader
    import cpu_mem_responder_pkg::*;
#(
    parameter int unsigned IMEM_AW = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_valid,
    input  logic [BYTE_W-1:0]   load_byte,
    input  logic                load_last,
    output logic                load_ready,
    output logic                cpu_reset,
    output logic                load_overflow,
    output logic                imem_we_c,
    output logic [IMEM_AW-1:0]  imem_waddr_c,
    output logic [WORD_W-1:0]   imem_wdata_c
);

    state_t             state;
    state_t             state_next;
    logic [1:0]         byte_cnt;
    // One extra bit: waddr saturates at IMEM depth, which marks overflow
    logic [IMEM_AW:0]   waddr;
    // Only the three most recent bytes are ever needed to build a word
    logic [23:0]        shift;
    logic               accept_c;
    logic               wr_word_c;
    logic [WORD_W-1:0]  word_c;

    // Next state, word assembly (zero-padded on a short final word), write port
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        wr_word_c  = 1'b0;
        unique case (byte_cnt)
            2'd0:    word_c = {load_byte, 24'h0};
            2'd1:    word_c = {shift[7:0], load_byte, 16'h0};
            2'd2:    word_c = {shift[15:0], load_byte, 8'h0};
            default: word_c = {shift[23:0], load_byte};
        endcase
        unique case (state)
            ST_LOAD: begin
                accept_c  = load_valid;
                wr_word_c = load_valid && (load_last || (byte_cnt == 2'd3));
                if (load_valid && load_last) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
            end
            default: state_next = ST_LOAD;
        endcase
        imem_we_c    = wr_word_c && !waddr[IMEM_AW];
        imem_waddr_c = waddr[IMEM_AW-1:0];
        imem_wdata_c = word_c;
    end

    // State register and loader datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_LOAD;
            byte_cnt      <= 2'd0;
            waddr         <= '0;
            shift         <= 24'h0;
            load_overflow <= 1'b0;
            load_ready    <= 1'b1;
            cpu_reset     <= 1'b1;
        end else begin
            state      <= state_next;
            load_ready <= (state_next == ST_LOAD);
            cpu_reset  <= (state_next == ST_LOAD);
            if (accept_c) begin
                shift    <= {shift[15:0], load_byte};
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (wr_word_c) begin
                if (waddr[IMEM_AW]) begin
                    load_overflow <= 1'b1;
                end else begin
                    waddr <= waddr + (IMEM_AW+1)'(1);
                end
            end
        end
    end

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for a single-cycle CPU: combinational instruction and
// data reads, clocked full-word data stores, and a boot loader that fills IMEM
// and drives the CPU reset.
// Optional feature macro: MEM_RESP_TOHOST_EN adds a tohost mailbox at
// TOHOST_ADDR with outputs tohost[31:0] and sticky halt.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   PC / instruction                 fetch address / word at IMEM[PC[IMEM_AW+1:2]]
//   mem_addr/mem_write_data/mem_wr   data port (stores ignored while loading)
//   mem_read_data                    word at DMEM[mem_addr[DMEM_AW+1:2]]
//   load_valid/load_byte/load_last/load_ready  boot byte stream
//   cpu_reset, load_overflow         loader status
module cpu_mem_responder
    import cpu_mem_responder_pkg::*;
#(
    parameter int unsigned IMEM_AW = 10,
    parameter int unsigned DMEM_AW = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WORD_W-1:0]   PC,
    output logic [WORD_W-1:0]   instruction,
    input  logic [WORD_W-1:0]   mem_addr,
    input  logic [WORD_W-1:0]   mem_write_data,
    input  logic                mem_wr,
    output logic [WORD_W-1:0]   mem_read_data,
    input  logic                load_valid,
    input  logic [BYTE_W-1:0]   load_byte,
    input  logic                load_last,
    output logic                load_ready,
    output logic                cpu_reset,
`ifdef MEM_RESP_TOHOST_EN
    output logic [WORD_W-1:0]   tohost,
    output logic                halt,
`endif
    output logic                load_overflow
);

    localparam int unsigned IMEM_DEPTH = 2**IMEM_AW;
    localparam int unsigned DMEM_DEPTH = 2**DMEM_AW;

    // Arrays are deliberately not reset; only control state is
    logic [WORD_W-1:0]  imem [IMEM_DEPTH];
    logic [WORD_W-1:0]  dmem [DMEM_DEPTH];

    logic               imem_we_c;
    logic [IMEM_AW-1:0] imem_waddr_c;
    logic [WORD_W-1:0]  imem_wdata_c;
    logic [IMEM_AW-1:0] iidx;
    logic [DMEM_AW-1:0] didx;
    logic               dmem_we_c;
    logic               unused_addr_bits;

    // Upper address bits wrap; byte offset is resolved in the CPU
    assign iidx = PC[IMEM_AW+1:2];
    assign didx = mem_addr[DMEM_AW+1:2];
    assign unused_addr_bits = ^{PC[WORD_W-1:IMEM_AW+2], PC[1:0],
                                mem_addr[WORD_W-1:DMEM_AW+2], mem_addr[1:0]};

    cpu_mem_responder_boot_loader #(
        .IMEM_AW (IMEM_AW)
    ) u_boot_loader (
        .clk           (clk),
        .reset         (reset),
        .load_valid    (load_valid),
        .load_byte     (load_byte),
        .load_last     (load_last),
        .load_ready    (load_ready),
        .cpu_reset     (cpu_reset),
        .load_overflow (load_overflow),
        .imem_we_c     (imem_we_c),
        .imem_waddr_c  (imem_waddr_c),
        .imem_wdata_c  (imem_wdata_c)
    );

    // IMEM write port, owned by the loader
    always_ff @(posedge clk) begin
        if (imem_we_c) begin
            imem[imem_waddr_c] <= imem_wdata_c;
        end
    end

    assign instruction = imem[iidx];

`ifdef MEM_RESP_TOHOST_EN
    logic tohost_hit_c;
    assign tohost_hit_c = (mem_addr == TOHOST_ADDR);
    assign dmem_we_c    = mem_wr && !cpu_reset && !tohost_hit_c;

    // Mailbox store replaces the DMEM write at that address
    always_ff @(posedge clk) begin
        if (reset) begin
            tohost <= '0;
            halt   <= 1'b0;
        end else if (mem_wr && !cpu_reset && tohost_hit_c) begin
            tohost <= mem_write_data;
            halt   <= 1'b1;
        end
    end

    assign mem_read_data = tohost_hit_c ? tohost : dmem[didx];
`else
    assign dmem_we_c     = mem_wr && !cpu_reset;
    assign mem_read_data = dmem[didx];
`endif

    // DMEM store, only once the CPU is running
    always_ff @(posedge clk) begin
        if (dmem_we_c) begin
            dmem[didx] <= mem_write_data;
        end
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: loader framing, padding, overflow,
// reset mid-load, DMEM store timing/aliasing and the optional tohost mailbox.
module tb_cpu_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_wr;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_last;

    logic [31:0] instruction, mem_read_data;
    logic        load_ready, cpu_reset, load_overflow;
    logic [31:0] instruction2, mem_read_data2;
    logic        load_ready2, cpu_reset2, load_overflow2;
`ifdef MEM_RESP_TOHOST_EN
    logic [31:0] tohost, tohost2;
    logic        halt, halt2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_mem_responder dut (
        .clk            (clk),
        .reset          (reset),
        .PC             (pc),
        .instruction    (instruction),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_wr         (mem_wr),
        .mem_read_data  (mem_read_data),
        .load_valid     (load_valid),
        .load_byte      (load_byte),
        .load_last      (load_last),
        .load_ready     (load_ready),
        .cpu_reset      (cpu_reset),
`ifdef MEM_RESP_TOHOST_EN
        .tohost         (tohost),
        .halt           (halt),
`endif
        .load_overflow  (load_overflow)
    );

    // Small IMEM instance for the overflow scenario
    cpu_mem_responder #(.IMEM_AW(2)) dut_small (
        .clk            (clk),
        .reset          (reset),
        .PC             (pc),
        .instruction    (instruction2),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_wr         (mem_wr),
        .mem_read_data  (mem_read_data2),
        .load_valid     (load_valid),
        .load_byte      (load_byte),
        .load_last      (load_last),
        .load_ready     (load_ready2),
        .cpu_reset      (cpu_reset2),
`ifdef MEM_RESP_TOHOST_EN
        .tohost         (tohost2),
        .halt           (halt2),
`endif
        .load_overflow  (load_overflow2)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        load_valid = 1'b1;
        load_byte  = b;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_byte  = 8'h00;
    endtask

    task automatic test_reset();
        reset = 1'b0; pc = '0; mem_addr = '0; mem_write_data = '0; mem_wr = 1'b0;
        load_valid = 1'b0; load_byte = '0; load_last = 1'b0;
        do_reset();
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready got %b exp 1", load_ready); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reset_cpu_reset got %b exp 1", cpu_reset); end
        checks++; if (load_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", load_overflow); end
`ifdef MEM_RESP_TOHOST_EN
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL reset_halt got %b exp 0", halt); end
        checks++; if (tohost !== 32'h0) begin errors++; $display("FAIL reset_tohost got %h exp 0", tohost); end
`endif
    endtask

    task automatic test_stream8();
        for (int i = 1; i <= 7; i++) send_byte(8'(i), 1'b0);
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL s8_cpu_reset_pre got %b exp 1", cpu_reset); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL s8_ready_pre got %b exp 1", load_ready); end
        send_byte(8'h08, 1'b1);
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL s8_cpu_reset_post got %b exp 0", cpu_reset); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL s8_ready_post got %b exp 0", load_ready); end
        pc = 32'h0; #1;
        checks++; if (instruction !== 32'h01020304) begin errors++; $display("FAIL s8_word0 got %h exp 01020304", instruction); end
        pc = 32'h4; #1;
        checks++; if (instruction !== 32'h05060708) begin errors++; $display("FAIL s8_word1 got %h exp 05060708", instruction); end
        pc = 32'h6; #1;
        checks++; if (instruction !== 32'h05060708) begin errors++; $display("FAIL s8_word1_unaligned got %h exp 05060708", instruction); end
        pc = 32'h4 + 32'd4096; #1;
        checks++; if (instruction !== 32'h05060708) begin errors++; $display("FAIL s8_word1_wrap got %h exp 05060708", instruction); end
    endtask

    task automatic test_partial();
        do_reset();
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL part_ready got %b exp 1", load_ready); end
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b1);
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL part_run got %b exp 0", cpu_reset); end
        pc = 32'h0; #1;
        checks++; if (instruction !== 32'hAABB0000) begin errors++; $display("FAIL part_word0 got %h exp AABB0000", instruction); end
        pc = 32'h4; #1;
        checks++; if (instruction !== 32'h05060708) begin errors++; $display("FAIL part_word1_kept got %h exp 05060708", instruction); end
    endtask

    task automatic test_dmem_write();
        mem_addr = 32'h10; mem_write_data = 32'h12345678; mem_wr = 1'b1;
        tick();
        mem_write_data = 32'hDEADBEEF; #1;
        checks++; if (mem_read_data !== 32'h12345678) begin errors++; $display("FAIL dm_same_cycle got %h exp 12345678", mem_read_data); end
        tick();
        mem_wr = 1'b0; #1;
        checks++; if (mem_read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL dm_0x10 got %h exp DEADBEEF", mem_read_data); end
        mem_addr = 32'h13; #1;
        checks++; if (mem_read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL dm_0x13 got %h exp DEADBEEF", mem_read_data); end
        mem_addr = 32'h10 + 32'd4096; #1;
        checks++; if (mem_read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL dm_wrap got %h exp DEADBEEF", mem_read_data); end
    endtask

    task automatic test_load_gaps();
        logic [7:0] seq_byte [8];
        logic       seq_valid [8];
        logic       seq_last [8];
        seq_byte  = '{8'hFF, 8'h21, 8'hFF, 8'h22, 8'hFF, 8'h23, 8'hFF, 8'h24};
        seq_valid = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        seq_last  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        do_reset();
        mem_addr = 32'h10; mem_write_data = 32'hCAFEF00D; mem_wr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            load_valid = seq_valid[i];
            load_byte  = seq_byte[i];
            load_last  = seq_last[i];
            tick();
            if (i == 6) begin
                checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL gap_last_unqualified got %b exp 1", cpu_reset); end
            end
        end
        mem_wr = 1'b0; load_valid = 1'b0; load_last = 1'b0; #1;
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL gap_run got %b exp 0", cpu_reset); end
        checks++; if (mem_read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL gap_dmem_kept got %h exp DEADBEEF", mem_read_data); end
        pc = 32'h0; #1;
        checks++; if (instruction !== 32'h21222324) begin errors++; $display("FAIL gap_word0 got %h exp 21222324", instruction); end
    endtask

    task automatic test_reset_midload();
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(8'(8'h61 + i), 1'b0);
        do_reset();
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL mid_cpu_reset got %b exp 1", cpu_reset); end
        send_byte(8'h11, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h14, 1'b1);
        pc = 32'h0; #1;
        checks++; if (instruction !== 32'h11121314) begin errors++; $display("FAIL mid_word0 got %h exp 11121314", instruction); end
        pc = 32'h4; #1;
        checks++; if (instruction !== 32'h05060708) begin errors++; $display("FAIL mid_word1 got %h exp 05060708", instruction); end
    endtask

    task automatic test_tohost();
        mem_addr = 32'h0000_0FF0; mem_write_data = 32'hA5A5A5A5; mem_wr = 1'b1;
        tick();
        mem_addr = 32'hFFFF_FFF0; mem_write_data = 32'h0000_0001;
        tick();
        mem_wr = 1'b0; #1;
`ifdef MEM_RESP_TOHOST_EN
        checks++; if (halt !== 1'b1) begin errors++; $display("FAIL th_halt got %b exp 1", halt); end
        checks++; if (tohost !== 32'h1) begin errors++; $display("FAIL th_tohost got %h exp 1", tohost); end
        checks++; if (mem_read_data !== 32'h1) begin errors++; $display("FAIL th_read got %h exp 1", mem_read_data); end
        mem_addr = 32'h0000_0FF0; #1;
        checks++; if (mem_read_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL th_dmem_kept got %h exp A5A5A5A5", mem_read_data); end
`else
        checks++; if (mem_read_data !== 32'h1) begin errors++; $display("FAIL alias_read got %h exp 1", mem_read_data); end
        mem_addr = 32'h0000_0FF0; #1;
        checks++; if (mem_read_data !== 32'h1) begin errors++; $display("FAIL alias_dmem got %h exp 1", mem_read_data); end
`endif
    endtask

    task automatic test_overflow();
        logic [31:0] exp_words [4];
        exp_words = '{32'h40414243, 32'h44454647, 32'h48494A4B, 32'h4C4D4E4F};
        do_reset();
        checks++; if (load_overflow2 !== 1'b0) begin errors++; $display("FAIL ovf_reset got %b exp 0", load_overflow2); end
        for (int i = 0; i < 19; i++) send_byte(8'(8'h40 + i), 1'b0);
        checks++; if (load_overflow2 !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", load_overflow2); end
        checks++; if (load_ready2 !== 1'b1) begin errors++; $display("FAIL ovf_ready got %b exp 1", load_ready2); end
        send_byte(8'h53, 1'b1);
        checks++; if (load_overflow2 !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", load_overflow2); end
        checks++; if (cpu_reset2 !== 1'b0) begin errors++; $display("FAIL ovf_run got %b exp 0", cpu_reset2); end
        for (int w = 0; w < 4; w++) begin
            pc = 32'(4 * w); #1;
            checks++; if (instruction2 !== exp_words[w]) begin errors++; $display("FAIL ovf_word%0d got %h exp %h", w, instruction2, exp_words[w]); end
        end
        pc = 32'd16; #1;
        checks++; if (instruction2 !== 32'h40414243) begin errors++; $display("FAIL ovf_wrap got %h exp 40414243", instruction2); end
        tick(); tick(); tick();
        checks++; if (load_overflow2 !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", load_overflow2); end
        do_reset();
        checks++; if (load_overflow2 !== 1'b0) begin errors++; $display("FAIL ovf_cleared got %b exp 0", load_overflow2); end
    endtask

    initial begin
        test_reset();
        test_stream8();
        test_partial();
        test_dmem_write();
        test_load_gaps();
        test_reset_midload();
        test_tohost();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
